// File: rtl/ram_sorter.sv
// In-place ascending bubble sort of a single-port registered-address RAM.
// Define RAM_SORTER_EARLY_EXIT_EN to stop after the first pass that makes no swaps.
module ram_sorter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int SWAP_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [SWAP_W-1:0] swaps
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_INIT = ADDR_W'(DEPTH - 2);

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        CAP,
        WR0,
        WR1,
        NEXT,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   i_q, i_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic                swapped_q, swapped_d;
    logic [SWAP_W-1:0]   swaps_q, swaps_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                finished;

    // A pass ends when i reaches last; the sort ends on the last pass (or on a clean pass).
`ifdef RAM_SORTER_EARLY_EXIT_EN
    assign finished = (last_q == '0) || !swapped_q;
`else
    assign finished = (last_q == '0);
`endif

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        last_d    = last_q;
        swapped_d = swapped_q;
        swaps_d   = swaps_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        a_d       = a_q;
        b_d       = b_q;
        busy      = 1'b1;
        done      = 1'b0;
        mem_wren  = 1'b0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    i_d       = '0;
                    last_d    = LAST_INIT;
                    swapped_d = 1'b0;
                    swaps_d   = '0;
                    state_d   = RD0;
                end
            end
            RD0: begin
                addr_d  = i_q;
                state_d = RD1;
            end
            RD1: begin
                addr_d  = i_q + ADDR_W'(1);
                a_d     = mem_rdata;
                state_d = CAP;
            end
            CAP: begin
                b_d     = mem_rdata;
                state_d = (a_q > mem_rdata) ? WR0 : NEXT;
            end
            WR0: begin
                addr_d   = i_q;
                wdata_d  = b_q;
                mem_wren = 1'b1;
                state_d  = WR1;
            end
            WR1: begin
                addr_d    = i_q + ADDR_W'(1);
                wdata_d   = a_q;
                mem_wren  = 1'b1;
                swapped_d = 1'b1;
                swaps_d   = swaps_q + SWAP_W'(1);
                state_d   = NEXT;
            end
            NEXT: begin
                if (i_q != last_q) begin
                    i_d     = i_q + ADDR_W'(1);
                    state_d = RD0;
                end else if (finished) begin
                    state_d = DONE;
                end else begin
                    last_d    = last_q - ADDR_W'(1);
                    i_d       = '0;
                    swapped_d = 1'b0;
                    state_d   = RD0;
                end
            end
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Address/data are driven combinationally so the RAM latches them on the same edge;
    // the registered copies hold the bus steady in the states that do not drive it.
    assign mem_addr  = addr_d;
    assign mem_wdata = wdata_d;
    assign swaps     = swaps_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            i_q       <= '0;
            last_q    <= LAST_INIT;
            swapped_q <= 1'b0;
            swaps_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            last_q    <= last_d;
            swapped_q <= swapped_d;
            swaps_q   <= swaps_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

endmodule

// File: tb/tb_ram_sorter.sv
// Self-checking bench for ram_sorter: behavioural RAM plus an inversion-count reference model.
module tb_ram_sorter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int SWAP_W = 10;
    localparam int DEPTH  = 32;
    localparam int BUDGET = 4000;
`ifdef RAM_SORTER_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_rdata;
    logic [SWAP_W-1:0] swaps;

    int n_checks = 0;
    int n_pass   = 0;

    ram_sorter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SWAP_W(SWAP_W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wren (mem_wren),
        .mem_rdata(mem_rdata),
        .swaps    (swaps)
    );

    always #5 clk = ~clk;

    // Registered-address single-port RAM
    logic [DATA_W-1:0] ram [DEPTH];
    logic [ADDR_W-1:0] ram_addr_r = '0;
    int                wr_count = 0;
    assign mem_rdata = ram[ram_addr_r];

    always @(posedge clk) begin
        if (mem_wren === 1'b1) begin
            ram[mem_addr] = mem_wdata;
            wr_count = wr_count + 1;
        end
        ram_addr_r <= mem_addr;
    end

    task automatic run_sort(input string name, input bit hold);
        logic [DATA_W-1:0] init [DEPTH];
        logic [DATA_W-1:0] exp_arr [DEPTH];
        int cnt [256];
        int inv, maxl, l, passes, compares, exp_cycles, cycles, w0, bad, bad_idx, k;
        for (int j = 0; j < DEPTH; j++) init[j] = ram[j];
        for (int v = 0; v < 256; v++) cnt[v] = 0;
        for (int j = 0; j < DEPTH; j++) cnt[init[j]]++;
        k = 0;
        for (int v = 0; v < 256; v++)
            for (int c = 0; c < cnt[v]; c++) begin
                exp_arr[k] = DATA_W'(v);
                k++;
            end
        inv  = 0;
        maxl = 0;
        for (int j = 0; j < DEPTH; j++) begin
            l = 0;
            for (int i = 0; i < j; i++) if (init[i] > init[j]) l++;
            inv += l;
            if (l > maxl) maxl = l;
        end
        passes = EARLY ? ((maxl + 1 < DEPTH - 1) ? maxl + 1 : DEPTH - 1) : DEPTH - 1;
        compares = 0;
        for (int p = 1; p <= passes; p++) compares += DEPTH - p;
        exp_cycles = 1 + 4 * compares + 2 * inv;

        w0 = wr_count;
        @(negedge clk);
        start  = 1'b1;
        cycles = 0;
        while (cycles < BUDGET) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (cycles == 2) begin
                n_checks++;
                if (busy !== 1'b1) $display("FAIL %s busy_during_sort: got %b want 1", name, busy);
                else n_pass++;
            end
            if (!hold && cycles == 3) start = 1'b0;
            if (done === 1'b1) break;
        end
        n_checks++;
        if (cycles !== exp_cycles) $display("FAIL %s done_latency: got %0d want %0d", name, cycles, exp_cycles);
        else n_pass++;
        n_checks++;
        if (int'(swaps) !== inv) $display("FAIL %s swaps: got %0d want %0d", name, swaps, inv);
        else n_pass++;
        bad = 0;
        bad_idx = -1;
        for (int j = 0; j < DEPTH; j++)
            if (ram[j] !== exp_arr[j]) begin
                bad++;
                if (bad_idx < 0) bad_idx = j;
            end
        n_checks++;
        if (bad != 0)
            $display("FAIL %s ram_contents: %0d words wrong, first at %0d got %h want %h",
                     name, bad, bad_idx, ram[bad_idx], exp_arr[bad_idx]);
        else n_pass++;
        n_checks++;
        if (wr_count - w0 !== 2 * inv) $display("FAIL %s write_count: got %0d want %0d", name, wr_count - w0, 2 * inv);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL %s busy_at_done: got %b want 0", name, busy);
        else n_pass++;
        if (cycles >= BUDGET) begin
            $display("FAIL %s timeout: waited %0d clks for done", name, cycles);
            start   = 1'b0;
            reset_n = 1'b0;
            @(negedge clk);
            reset_n = 1'b1;
        end else if (!hold) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0) $display("FAIL %s done_clears: got %b want 0", name, done);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, mem_wren} !== 3'b000) $display("FAIL reset_ctrl: got busy/done/wren=%b want 000", {busy, done, mem_wren});
        else n_pass++;
        n_checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) $display("FAIL reset_bus: got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
        else n_pass++;
        n_checks++;
        if (swaps !== '0) $display("FAIL reset_swaps: got %0d want 0", swaps);
        else n_pass++;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) $display("FAIL idle_after_reset: got busy/done=%b want 00", {busy, done});
        else n_pass++;
    endtask

    task automatic test_ascending();
        for (int j = 0; j < DEPTH; j++) ram[j] = DATA_W'(j);
        run_sort("ascending", 1'b0);
    endtask

    task automatic test_descending();
        for (int j = 0; j < DEPTH; j++) ram[j] = DATA_W'(DEPTH - 1 - j);
        run_sort("descending", 1'b1);
    endtask

    task automatic test_done_hold();
        int cycles;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if ({done, busy} !== 2'b10) $display("FAIL hold_done: got done/busy=%b want 10", {done, busy});
            else n_pass++;
        end
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({done, busy} !== 2'b00) $display("FAIL drop_start: got done/busy=%b want 00", {done, busy});
        else n_pass++;
        start = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || swaps !== '0) $display("FAIL restart: got busy=%b swaps=%0d want 1 and 0", busy, swaps);
        else n_pass++;
        cycles = 0;
        while (done !== 1'b1 && cycles < BUDGET) begin
            @(negedge clk);
            cycles++;
        end
        n_checks++;
        if (done !== 1'b1) $display("FAIL restart_done: got done=%b after %0d clks want 1", done, cycles);
        else n_pass++;
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_all_equal();
        for (int j = 0; j < DEPTH; j++) ram[j] = 8'h55;
        run_sort("all_equal", 1'b0);
    endtask

    task automatic test_ff_first();
        ram[0] = 8'hFF;
        for (int j = 1; j < DEPTH; j++) ram[j] = DATA_W'(j);
        run_sort("ff_first", 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            for (int j = 0; j < DEPTH; j++)
                ram[j] = (t % 2 == 1) ? DATA_W'($urandom_range(0, 3)) : DATA_W'($urandom_range(0, 255));
            run_sort($sformatf("random%0d", t), 1'b0);
        end
    endtask

    task automatic test_mid_reset();
        for (int j = 0; j < DEPTH; j++) ram[j] = DATA_W'(DEPTH - 1 - j);
        @(negedge clk);
        start = 1'b1;
        repeat (200) @(posedge clk);
        #3;
        reset_n = 1'b0;
        start   = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, mem_wren} !== 3'b000) $display("FAIL midreset_ctrl: got busy/done/wren=%b want 000", {busy, done, mem_wren});
        else n_pass++;
        n_checks++;
        if (swaps !== '0 || mem_addr !== '0) $display("FAIL midreset_regs: got swaps=%0d addr=%h want 0", swaps, mem_addr);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_sort("after_reset", 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        test_reset();
        test_ascending();
        test_descending();
        test_done_hold();
        test_all_equal();
        test_ff_first();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
